// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper and its sample voter.
package tt_sweep_pkg;

  localparam int N_INPUTS = 3;
  localparam int TT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    COMMIT,
    DONE
  } state_e;

  // Bits needed to hold a count from 0 up to n inclusive, never less than 1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_vote.sv
// Ones-counter over a burst of samples with a majority decision on the count.
module sample_vote
  import tt_sweep_pkg::*;
#(
  parameter int SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic bit_in,
  output logic vote
);

  localparam int OW = cnt_width(SAMPLES);

  logic [OW-1:0] ones_q;
  logic [OW-1:0] ones_d;

  always_comb begin
    ones_d = ones_q;
    if (clear) begin
      ones_d = '0;
    end else if (en && bit_in) begin
      ones_d = ones_q + OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign vote = (ones_q > OW'(SAMPLES / 2));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through all 8 vectors, majority-samples its output and
// assembles the observed truth table for comparison against a reference.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int                  SETTLE_CYCLES = 4,
  parameter int                  SAMPLES       = 3,
  parameter logic [TT_WIDTH-1:0] EXPECTED      = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                dut_out,
  output logic                in1,
  output logic                in2,
  output logic                in3,
  output logic                busy,
  output logic                done,
  output logic [TT_WIDTH-1:0] table_word,
  output logic                match
);

  localparam int SW = cnt_width(SETTLE_CYCLES);
  localparam int CW = cnt_width(SAMPLES);
  localparam logic [SW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;
  localparam logic [CW-1:0] SAMPLE_LOAD = CW'(SAMPLES - 1);
  localparam logic [N_INPUTS-1:0] LAST_VECTOR = N_INPUTS'(TT_WIDTH - 1);
  localparam state_e FIRST_WAIT = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_e                state_q, state_d;
  logic [N_INPUTS-1:0]   vector_q, vector_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic [CW-1:0]         samp_q, samp_d;
  logic [TT_WIDTH-1:0]   table_q, table_d;
  logic                  match_q, match_d;
  logic                  vote;
  logic                  in_flight;

  assign in_flight = (state_q == SETTLE) || (state_q == SAMPLE) || (state_q == COMMIT);

  sample_vote #(
    .SAMPLES(SAMPLES)
  ) u_vote (
    .clk   (clk),
    .rst   (rst),
    .clear ((state_q == IDLE) || (state_q == COMMIT)),
    .en    (state_q == SAMPLE),
    .bit_in(dut_out),
    .vote  (vote)
  );

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    settle_d = settle_q;
    samp_d   = samp_q;
    table_d  = table_q;
    match_d  = match_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          vector_d = '0;
          table_d  = '0;
          match_d  = 1'b0;
          settle_d = SETTLE_LOAD;
          samp_d   = SAMPLE_LOAD;
          state_d  = FIRST_WAIT;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          samp_d  = SAMPLE_LOAD;
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      SAMPLE: begin
        if (samp_q == '0) begin
          state_d = COMMIT;
        end else begin
          samp_d = samp_q - CW'(1);
        end
      end
      COMMIT: begin
        table_d[vector_q] = vote;
        if (vector_q != LAST_VECTOR) begin
          vector_d = vector_q + N_INPUTS'(1);
          settle_d = SETTLE_LOAD;
          samp_d   = SAMPLE_LOAD;
          state_d  = FIRST_WAIT;
        end else begin
          match_d = (table_d == EXPECTED);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides whatever the sweep was about to do, including a pending commit.
    if (abort && in_flight) begin
      state_d  = IDLE;
      vector_d = vector_q;
      table_d  = table_q;
      match_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vector_q <= '0;
      settle_q <= '0;
      samp_q   <= '0;
      table_q  <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vector_q <= vector_d;
      settle_q <= settle_d;
      samp_q   <= samp_d;
      table_q  <= table_d;
      match_q  <= match_d;
    end
  end

  assign {in1, in2, in3} = (state_q == IDLE) ? '0 : vector_q;
  assign busy            = in_flight;
  assign done            = (state_q == DONE);
  assign table_word      = table_q;
  assign match           = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: ideal, wrong-function, glitching,
// aborted, reset and delayed gate models against hand-computed truth tables.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst;
  logic       abort;

  // Default-parameter instance (SETTLE_CYCLES=4, SAMPLES=3, EXPECTED=A5)
  logic       start_d, dut_out_d, in1_d, in2_d, in3_d, busy_d, done_d, match_d;
  logic [7:0] table_d;

  // Fast instance (SETTLE_CYCLES=0, SAMPLES=1) fed by a slow gate
  logic       start_f, dut_out_f, in1_f, in2_f, in3_f, busy_f, done_f, match_f;
  logic [7:0] table_f;

  int         total;
  int         bad;
  int         cyc;
  int         done_cnt;
  int         done_cyc;
  int         busy_err;
  logic       match_at_done;

  int         mode;
  logic       glitch_en;
  logic [7:0] word_a5;
  logic [7:0] word_model;
  logic [2:0] pipe_d [3];
  logic [2:0] pipe_f [3];

  truth_table_sweeper u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start_d),
    .abort     (abort),
    .dut_out   (dut_out_d),
    .in1       (in1_d),
    .in2       (in2_d),
    .in3       (in3_d),
    .busy      (busy_d),
    .done      (done_d),
    .table_word(table_d),
    .match     (match_d)
  );

  truth_table_sweeper #(
    .SETTLE_CYCLES(0),
    .SAMPLES      (1),
    .EXPECTED     (8'hA5)
  ) u_fast (
    .clk       (clk),
    .rst       (rst),
    .start     (start_f),
    .abort     (abort),
    .dut_out   (dut_out_f),
    .in1       (in1_f),
    .in2       (in2_f),
    .in3       (in3_f),
    .busy      (busy_f),
    .done      (done_f),
    .table_word(table_f),
    .match     (match_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign word_a5    = 8'hA5;
  assign word_model = (mode == 1) ? 8'h96 : 8'hA5;

  // Gate models: mode 0 ideal A5, mode 1 ideal 96, mode 2 A5 seen through three flops
  always @(posedge clk) begin
    pipe_d[0] <= {in1_d, in2_d, in3_d};
    pipe_d[1] <= pipe_d[0];
    pipe_d[2] <= pipe_d[1];
    pipe_f[0] <= {in1_f, in2_f, in3_f};
    pipe_f[1] <= pipe_f[0];
    pipe_f[2] <= pipe_f[1];
  end

  assign dut_out_d = ((mode == 2) ? word_model[pipe_d[2]] : word_model[{in1_d, in2_d, in3_d}])
                     ^ (glitch_en && (cyc == 30));
  assign dut_out_f = word_a5[pipe_f[2]];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One clock step; start and abort are single-cycle pulses.
  task automatic tick();
    @(negedge clk);
    cyc++;
    start_d = 1'b0;
    start_f = 1'b0;
    abort   = 1'b0;
  endtask

  // Raises start for the current cycle, which becomes cycle 0 of the sweep.
  task automatic applyStimulus(input bit fast);
    if (fast) start_f = 1'b1;
    else      start_d = 1'b1;
    cyc           = 0;
    done_cnt      = 0;
    done_cyc      = -1;
    busy_err      = 0;
    match_at_done = 1'b0;
  endtask

  task automatic watch(input bit fast, input int until_cyc, input int busy_hi);
    logic d, b, m;
    while (cyc < until_cyc) begin
      tick();
      d = fast ? done_f  : done_d;
      b = fast ? busy_f  : busy_d;
      m = fast ? match_f : match_d;
      if (d) begin
        done_cnt++;
        done_cyc      = cyc;
        match_at_done = m;
      end
      if (busy_hi > 0 && b !== ((cyc >= 1) && (cyc <= busy_hi))) busy_err++;
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    cyc       = 0;
    mode      = 0;
    glitch_en = 1'b0;
    rst       = 1'b1;
    start_d   = 1'b0;
    start_f   = 1'b0;
    abort     = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();

    checkOutput("reset_busy",  busy_d, 0);
    checkOutput("reset_done",  done_d, 0);
    checkOutput("reset_table", table_d, 8'h00);
    checkOutput("reset_match", match_d, 0);
    checkOutput("reset_in",    {in1_d, in2_d, in3_d}, 0);

    // Ideal A5 gate
    mode = 0;
    applyStimulus(0);
    watch(0, 70, 64);
    checkOutput("t1_done_cycle", done_cyc, 65);
    checkOutput("t1_done_count", done_cnt, 1);
    checkOutput("t1_busy_window", busy_err, 0);
    checkOutput("t1_match_at_done", match_at_done, 1);
    checkOutput("t1_table", table_d, 8'hA5);
    checkOutput("t1_match_held", match_d, 1);
    checkOutput("t1_in_idle", {in1_d, in2_d, in3_d}, 0);

    // Wrong function 96 against reference A5
    mode = 1;
    applyStimulus(0);
    watch(0, 70, 64);
    checkOutput("t2_done_cycle", done_cyc, 65);
    checkOutput("t2_table", table_d, 8'h96);
    checkOutput("t2_match", match_d, 0);

    // One inverted sample during vector 3 is outvoted
    mode      = 0;
    glitch_en = 1'b1;
    applyStimulus(0);
    watch(0, 70, 64);
    glitch_en = 1'b0;
    checkOutput("t3_table", table_d, 8'hA5);
    checkOutput("t3_match", match_d, 1);
    checkOutput("t3_done_cycle", done_cyc, 65);

    // Abort in cycle 30: vectors 0..2 already committed
    applyStimulus(0);
    watch(0, 30, 0);
    checkOutput("t4_in_before_abort", {in1_d, in2_d, in3_d}, 3);
    abort = 1'b1;
    watch(0, 31, 0);
    checkOutput("t4_abort_busy", busy_d, 0);
    checkOutput("t4_abort_in", {in1_d, in2_d, in3_d}, 0);
    checkOutput("t4_abort_match", match_d, 0);
    watch(0, 80, 0);
    checkOutput("t4_abort_no_done", done_cnt, 0);
    checkOutput("t4_partial_table", table_d, 8'h05);
    applyStimulus(0);
    abort = 1'b1;
    watch(0, 10, 0);
    checkOutput("t4_abort_beats_start", done_cnt + int'(busy_d), 0);
    checkOutput("t4_start_dropped_table", table_d, 8'h05);
    applyStimulus(0);
    watch(0, 70, 64);
    checkOutput("t4_rerun_table", table_d, 8'hA5);
    checkOutput("t4_rerun_match", match_d, 1);
    checkOutput("t4_rerun_done_cycle", done_cyc, 65);

    // Restart attempt in cycle 20, reset in cycle 40
    applyStimulus(0);
    watch(0, 20, 0);
    start_d = 1'b1;
    watch(0, 22, 0);
    checkOutput("t5_restart_ignored_in", {in1_d, in2_d, in3_d}, 2);
    checkOutput("t5_restart_busy", busy_d, 1);
    watch(0, 40, 0);
    rst = 1'b1;
    watch(0, 41, 0);
    rst = 1'b0;
    checkOutput("t5_rst_busy",  busy_d, 0);
    checkOutput("t5_rst_done",  done_d, 0);
    checkOutput("t5_rst_table", table_d, 8'h00);
    checkOutput("t5_rst_match", match_d, 0);
    checkOutput("t5_rst_in",    {in1_d, in2_d, in3_d}, 0);
    watch(0, 80, 0);
    checkOutput("t5_no_done", done_cnt, 0);

    // Gate with three cycles of output delay: default settle hides it
    mode = 2;
    applyStimulus(0);
    watch(0, 70, 64);
    checkOutput("t6_slow_table", table_d, 8'hA5);
    checkOutput("t6_slow_match", match_d, 1);

    // Same slow gate on the zero-settle, single-sample instance: bit v sees f(max(v-2,0))
    applyStimulus(1);
    watch(1, 25, 16);
    checkOutput("t6_fast_done_cycle", done_cyc, 17);
    checkOutput("t6_fast_done_count", done_cnt, 1);
    checkOutput("t6_fast_busy_window", busy_err, 0);
    checkOutput("t6_fast_table", table_f, 8'h97);
    checkOutput("t6_fast_match", match_f, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
